c_wl_seq: RTL and testbench
===========================

# c_wl_seq

Write sequencer for the switch/sign wordline array of one VPE group. It accepts a stream of configuration bits over a valid/ready handshake and walks the 5 × 61 cell address space. For each cell it drives the `VPE_XIDX` / `SW_IN_VPE` address pair, which feeds `C_WL_DEC`, together with a timed `WL_EN` strobe and the bitline data `BL_DATA`. It sits between the configuration loader and the wordline decoder, and it is the only block that sources decoder addresses.

## Interface
Parameters:
- `SETUP_CYC`, default 1: cycles the address and `BL_DATA` are stable before `WL_EN` rises; legal range 1..255.
- `PULSE_CYC`, default 4: cycles `WL_EN` stays high per cell; legal range 1..255.
- `HOLD_CYC`, default 1: cycles the address and `BL_DATA` are held after `WL_EN` falls; legal range 1..255.

Ports:
- `CLK`  in  1  clock.
- `RSTN`  in  1  reset; synchronous, active-low.
- `START`  in  1  begin a programming pass; sampled only in IDLE.
- `CFG_VALID`  in  1  configuration bit valid.
- `CFG_BIT`  in  1  value to write into the current cell.
- `CFG_READY`  out  1  sequencer can accept a bit.
- `VPE_XIDX`  out  3  VPE index, 0..4; drives `C_WL_DEC`.
- `SW_IN_VPE`  out  6  cell index in the VPE, 0..60; 60 is the sign cell.
- `WL_EN`  out  1  wordline write strobe; the decoder outputs are gated by this strobe downstream.
- `BL_DATA`  out  1  bitline write data.
- `BUSY`  out  1  high from pass start until `DONE`.
- `DONE`  out  1  one-cycle pulse at the end of a pass.

## Operation
- FSM states: IDLE, LOAD, SETUP, PULSE, HOLD.
- **IDLE**
  - Address is 0/0. `BUSY`=0 and `CFG_READY`=0.
  - `START`=1 moves to LOAD and sets `BUSY`=1.
- **LOAD**
  - `CFG_READY`=1.
  - On `CFG_VALID` && `CFG_READY`: register `CFG_BIT` into `BL_DATA`, load the phase counter, go to SETUP.
  - With no valid, stay in LOAD indefinitely. The address is held.
- **SETUP**: lasts `SETUP_CYC` cycles with `WL_EN`=0, then goes to PULSE.
- **PULSE**: lasts `PULSE_CYC` cycles with `WL_EN`=1, then goes to HOLD.
- **HOLD**: lasts `HOLD_CYC` cycles with `WL_EN`=0, then advances the address.
- **Address advance**
  - `SW_IN_VPE` increments 0..60. After 60 it wraps to 0 and `VPE_XIDX` increments.
  - After cell (4,60), pulse `DONE`, set `BUSY`=0, return the address to 0/0 and go to IDLE.
  - Otherwise go back to LOAD.
- `VPE_XIDX` never exceeds 4 and `SW_IN_VPE` never exceeds 60.
- `VPE_XIDX`, `SW_IN_VPE` and `BL_DATA` are constant from the LOAD handshake through the last HOLD cycle of the same cell.
- `START` outside IDLE is ignored. `CFG_VALID` outside LOAD is ignored because `CFG_READY`=0.
- A cycle with `RSTN`=0 in any state, including mid-pulse, forces IDLE and all outputs to their reset values on the next edge. The partial pass is abandoned.

## Timing
- Reset values: `VPE_XIDX`=0, `SW_IN_VPE`=0, `WL_EN`=0, `BL_DATA`=0, `CFG_READY`=0, `BUSY`=0, `DONE`=0.
- All outputs are registered. There are no combinational input-to-output paths.
- `START` accepted at edge t: `BUSY` and `CFG_READY` are high from t+1.
- Handshake at edge h:
  - SETUP occupies cycles h+1..h+`SETUP_CYC`.
  - `WL_EN` is high for the next `PULSE_CYC` cycles.
  - HOLD follows.
  - `CFG_READY` rises again one cycle after the last HOLD cycle.
- Per-cell cost with `CFG_VALID` held high is 1+`SETUP_CYC`+`PULSE_CYC`+`HOLD_CYC` cycles; 7 at the defaults.
- A full pass is 305 cells, i.e. 2135 cycles at the defaults, excluding the `START` cycle.
- `DONE` is high in the cycle after the final HOLD cycle. The FSM is in IDLE in that same cycle, so a `START` sampled then begins a new pass.
- The phase counter is 8 bits and reloads at each state entry.

## Configuration
- Macro `C_WL_SEQ_SKIP_SIGN_EN`.
- **When defined**
  - The sign cell `SW_IN_VPE`=60 is never addressed: the index wraps 59→0.
  - A pass is 300 cells and ends after (4,59). It consumes 300 bits.
- **When undefined**
  - All 305 cells are programmed, including the sign cells.

## Test plan
- **Reset:** hold `RSTN`=0 for 3 cycles with `START`=1 → all outputs 0 and the FSM in IDLE.
- **Full pass, defaults:** `START` pulse, `CFG_VALID` held 1, `CFG_BIT` alternating → 305 `WL_EN` pulses, each 4 cycles wide.
  - Per pulse: `BL_DATA` matches the accepted bit and the address stays constant across its 7-cycle window.
  - `DONE` arrives 2135 cycles after `START`.
  - The address sequence is (0,0)…(0,60),(1,0)…(4,60).
- **Backpressure:** drop `CFG_VALID` for 10 cycles in LOAD at cell (2,17) → `CFG_READY` stays 1, `WL_EN` stays 0, the address stays (2,17), and the pass resumes on the next valid.
- **Reset mid-operation:** assert `RSTN`=0 during PULSE of (1,5) → next cycle `WL_EN`=0, address 0/0, `BUSY`=0.
  - A subsequent `START` restarts the pass at (0,0).
- **Ignored `START`:** assert `START` every cycle during a pass → no restart, and exactly one `DONE`.
- **`C_WL_SEQ_SKIP_SIGN_EN` defined:** run a full pass → `SW_IN_VPE` never equals 60, there are 300 pulses, and `DONE` arrives after 2100 cycles.

Source files
------------

// File: rtl/c_wl_seq.sv
// Write sequencer for one VPE group's switch/sign wordline array: walks the 5 x 61 cell space,
// driving the C_WL_DEC address, a timed WL_EN strobe and BL_DATA. Optional macro: C_WL_SEQ_SKIP_SIGN_EN.
module c_wl_seq #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 1
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       START,
  input  logic       CFG_VALID,
  input  logic       CFG_BIT,
  output logic       CFG_READY,
  output logic [2:0] VPE_XIDX,
  output logic [5:0] SW_IN_VPE,
  output logic       WL_EN,
  output logic       BL_DATA,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_PULSE = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  localparam logic [2:0] LAST_VPE = 3'd4;
`ifdef C_WL_SEQ_SKIP_SIGN_EN
  localparam logic [5:0] LAST_CELL = 6'd59;
`else
  localparam logic [5:0] LAST_CELL = 6'd60;
`endif

  // Counter is loaded with length-1 so the state ends when it reads zero.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] xidx_q, xidx_d;
  logic [5:0] sw_q, sw_d;
  logic       bl_q, bl_d;
  logic       wl_q, wl_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Output flops are computed from the next state so every output is registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xidx_d  = xidx_q;
    sw_d    = sw_q;
    bl_d    = bl_q;
    wl_d    = 1'b0;
    ready_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_LOAD;
          ready_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        ready_d = 1'b1;
        if (CFG_VALID && ready_q) begin
          bl_d    = CFG_BIT;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
          ready_d = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
          wl_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_PULSE: begin
        wl_d = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          wl_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (xidx_q == LAST_VPE && sw_q == LAST_CELL) begin
          state_d = ST_IDLE;
          xidx_d  = 3'd0;
          sw_d    = 6'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_LOAD;
          ready_d = 1'b1;
          if (sw_q == LAST_CELL) begin
            sw_d   = 6'd0;
            xidx_d = xidx_q + 3'd1;
          end else begin
            sw_d = sw_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        xidx_d  = 3'd0;
        sw_d    = 6'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      xidx_q  <= 3'd0;
      sw_q    <= 6'd0;
      bl_q    <= 1'b0;
      wl_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xidx_q  <= xidx_d;
      sw_q    <= sw_d;
      bl_q    <= bl_d;
      wl_q    <= wl_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign CFG_READY = ready_q;
  assign VPE_XIDX  = xidx_q;
  assign SW_IN_VPE = sw_q;
  assign WL_EN     = wl_q;
  assign BL_DATA   = bl_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_c_wl_seq.sv
// Self-checking bench for c_wl_seq at default timing: directed vector table for the first cells,
// then full passes (plain, backpressure plus repeated START) and a reset during a pulse.
module tb_c_wl_seq;

  localparam int PULSE_CYC = 4;
  localparam int CELL_CYC  = 7;
`ifdef C_WL_SEQ_SKIP_SIGN_EN
  localparam int LAST_S = 59;
`else
  localparam int LAST_S = 60;
`endif
  localparam int CELLS = 5 * (LAST_S + 1);

  logic       CLK;
  logic       RSTN;
  logic       START;
  logic       CFG_VALID;
  logic       CFG_BIT;
  logic       CFG_READY;
  logic [2:0] VPE_XIDX;
  logic [5:0] SW_IN_VPE;
  logic       WL_EN;
  logic       BL_DATA;
  logic       BUSY;
  logic       DONE;

  int checkCount = 0;
  int errorCount = 0;

  c_wl_seq dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .START     (START),
    .CFG_VALID (CFG_VALID),
    .CFG_BIT   (CFG_BIT),
    .CFG_READY (CFG_READY),
    .VPE_XIDX  (VPE_XIDX),
    .SW_IN_VPE (SW_IN_VPE),
    .WL_EN     (WL_EN),
    .BL_DATA   (BL_DATA),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rstn;
    logic        start;
    logic        valid;
    logic        cbit;
    logic [13:0] expOut;
  } vecT;

  vecT vecs[16];

  function automatic logic [13:0] packOut(input logic ready, input logic wl, input logic bl,
                                          input logic busy, input logic done,
                                          input logic [2:0] x, input logic [5:0] s);
    return {ready, wl, bl, busy, done, x, s};
  endfunction

  function automatic int obsVec();
    return int'({18'd0, CFG_READY, WL_EN, BL_DATA, BUSY, DONE, VPE_XIDX, SW_IN_VPE});
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstn, input logic start, input logic valid, input logic cbit);
    RSTN      = rstn;
    START     = start;
    CFG_VALID = valid;
    CFG_BIT   = cbit;
    @(posedge CLK);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    RSTN = 1'b1;
  endtask

  // One complete pass with CFG_VALID high, alternating bits, and a model of the cell walk.
  task automatic runPass(input bit bpEnable, input bit startSpam, input string tag);
    int mx = 0, ms = 0, cellX = 0, cellS = 0;
    int pulses = 0, width = 0, widthErr = 0, winErr = 0, bpErr = 0, bpLeft = 0;
    int busyCycles = 0, doneCount = 0, doneCyc = -1, maxS = 0, extra = 0;
    int obsX = 0, obsS = 0;
    bit bpDone = 0, prevReady = 0, prevWl = 0, hs = 0, nextBit = 1, accBit = 0, finished = 0;
    resetDut();
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      START = (cyc == 0) || startSpam;
      if (bpEnable && !bpDone && bpLeft == 0 && prevReady && obsX == 2 && obsS == 17)
        bpLeft = 10;
      CFG_VALID = (bpLeft == 0);
      CFG_BIT   = nextBit;
      hs = prevReady && CFG_VALID;
      if (hs) begin
        accBit = nextBit;
        cellX  = mx;
        cellS  = ms;
        if (ms == LAST_S) begin
          ms = 0;
          mx++;
        end else begin
          ms++;
        end
      end
      @(posedge CLK);
      #1;
      if (hs) nextBit = ~nextBit;
      if (bpLeft > 0) begin
        if (CFG_READY !== 1'b1 || WL_EN !== 1'b0 || VPE_XIDX !== 3'd2 || SW_IN_VPE !== 6'd17)
          bpErr++;
        bpLeft--;
        if (bpLeft == 0) bpDone = 1;
      end
      if (BUSY) busyCycles++;
      if (WL_EN && !prevWl) begin
        pulses++;
        width = 1;
      end else if (WL_EN) begin
        width++;
      end
      if (!WL_EN && prevWl && width != PULSE_CYC) widthErr++;
      if (BUSY && !CFG_READY &&
          (int'(VPE_XIDX) != cellX || int'(SW_IN_VPE) != cellS || BL_DATA != accBit))
        winErr++;
      if (int'(SW_IN_VPE) > maxS) maxS = int'(SW_IN_VPE);
      if (DONE) begin
        doneCount++;
        doneCyc  = cyc;
        finished = 1;
      end
      prevReady = CFG_READY;
      prevWl    = WL_EN;
      obsX      = int'(VPE_XIDX);
      obsS      = int'(SW_IN_VPE);
    end
    START     = 1'b0;
    CFG_VALID = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) doneCount++;
      if (BUSY) extra++;
    end
    checkOutput({tag, "_pulses"}, pulses, CELLS);
    checkOutput({tag, "_pulse_width_errs"}, widthErr, 0);
    checkOutput({tag, "_window_errs"}, winErr, 0);
    checkOutput({tag, "_done_count"}, doneCount, 1);
    checkOutput({tag, "_done_cycle"}, doneCyc, CELLS * CELL_CYC + (bpEnable ? 10 : 0));
    checkOutput({tag, "_busy_cycles"}, busyCycles, CELLS * CELL_CYC + (bpEnable ? 10 : 0));
    checkOutput({tag, "_max_sw"}, maxS, LAST_S);
    checkOutput({tag, "_busy_after_done"}, extra, 0);
    if (bpEnable) begin
      checkOutput({tag, "_bp_seen"}, int'(bpDone), 1);
      checkOutput({tag, "_bp_errs"}, bpErr, 0);
    end
  endtask

  task automatic resetMidPulse();
    bit found = 0;
    bit pulseSeen = 0;
    resetDut();
    CFG_VALID = 1'b1;
    CFG_BIT   = 1'b1;
    START     = 1'b1;
    for (int cyc = 0; cyc < 2000 && !found; cyc++) begin
      @(posedge CLK);
      #1;
      START = 1'b0;
      if (WL_EN && VPE_XIDX == 3'd1 && SW_IN_VPE == 6'd5) found = 1;
    end
    checkOutput("midreset_reached_1_5", int'(found), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("midreset_outputs", obsVec(), 0);
    RSTN  = 1'b1;
    START = 1'b1;
    for (int cyc = 0; cyc < 20 && !pulseSeen; cyc++) begin
      @(posedge CLK);
      #1;
      START = 1'b0;
      if (WL_EN) begin
        pulseSeen = 1;
        checkOutput("restart_first_addr", int'({VPE_XIDX, SW_IN_VPE}), 0);
      end
    end
    checkOutput("restart_pulse_seen", int'(pulseSeen), 1);
    CFG_VALID = 1'b0;
  endtask

  initial begin
    RSTN = 1'b0; START = 1'b0; CFG_VALID = 1'b0; CFG_BIT = 1'b0;

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, packOut(0, 0, 0, 0, 0, 3'd0, 6'd0)};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, packOut(0, 0, 0, 0, 0, 3'd0, 6'd0)};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, packOut(0, 0, 0, 0, 0, 3'd0, 6'd0)};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, packOut(0, 0, 0, 0, 0, 3'd0, 6'd0)};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, packOut(1, 0, 0, 1, 0, 3'd0, 6'd0)};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, packOut(1, 0, 0, 1, 0, 3'd0, 6'd0)};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, packOut(0, 0, 1, 1, 0, 3'd0, 6'd0)};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, packOut(0, 1, 1, 1, 0, 3'd0, 6'd0)};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, packOut(0, 1, 1, 1, 0, 3'd0, 6'd0)};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, packOut(0, 1, 1, 1, 0, 3'd0, 6'd0)};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, packOut(0, 1, 1, 1, 0, 3'd0, 6'd0)};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, packOut(0, 0, 1, 1, 0, 3'd0, 6'd0)};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, packOut(1, 0, 1, 1, 0, 3'd0, 6'd1)};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, packOut(0, 0, 0, 1, 0, 3'd0, 6'd1)};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b1, packOut(0, 1, 0, 1, 0, 3'd0, 6'd1)};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, packOut(0, 0, 0, 0, 0, 3'd0, 6'd0)};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].start, vecs[i].valid, vecs[i].cbit);
      checkOutput($sformatf("vec%0d", i), obsVec(), int'(vecs[i].expOut));
    end

    $display("[TB] full pass, defaults");
    runPass(1'b0, 1'b0, "pass");
    $display("[TB] full pass with backpressure at (2,17) and START held high");
    runPass(1'b1, 1'b1, "bpstart");
    $display("[TB] reset during pulse of (1,5)");
    resetMidPulse();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
